adder_result_merge: RTL
=======================

# adder_result_merge

Collects results from the 4-bit small-adder path and the 8-bit large-adder path of the variable-width adder and merges them into one in-order result stream. Each path's result is zero-extended to a common 9-bit width and tagged with its source path. Results are buffered in a small FIFO and presented downstream over a valid/ready handshake. The block sits between the adder pair and the downstream consumer, acting as the return leg of the operand dispatcher.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- CW, 16, width of per-path accept counters
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  small-path result valid
- s_sum  in  4  small-path sum
- s_cout  in  1  small-path carry-out
- s_ready  out  1  small-path result accepted this cycle when high with s_valid
- l_valid  in  1  large-path result valid
- l_sum  in  8  large-path sum
- l_cout  in  1  large-path carry-out
- l_ready  out  1  large-path result accepted this cycle when high with l_valid
- out_valid  out  1  head entry available
- out_ready  in  1  consumer accepts head entry
- out_sum  out  9  merged result, value of head entry
- out_path  out  1  source of head entry: 0 = small, 1 = large
- level  out  clog2(DEPTH)+1  current FIFO occupancy
- s_count  out  CW  small-path results accepted since reset, wraps
- l_count  out  CW  large-path results accepted since reset, wraps

## Operation
- Result formation: small → {4'b0, s_cout, s_sum}, path 0; large → {l_cout, l_sum}, path 1.
- At most one write per cycle. Write condition: selected source valid and FIFO not full.
- Arbitration uses a round-robin flag rr (reset 0 = small preferred).
  - Only s_valid: grant small. Only l_valid: grant large.
  - Both valid: grant small if rr=0, otherwise large.
  - On every accepted write, rr is set to 1 after a small grant and to 0 after a large grant.
- s_ready = !full && (!l_valid || rr==0). l_ready = !full && (!s_valid || rr==1). The readies are combinational, and at most one is high while both sources are valid.
- A full FIFO blocks writes even if a pop occurs in the same cycle. There is no pass-through path.
- Read: out_valid = (level != 0). out_sum and out_path are driven from the head storage, show-ahead. Pop occurs when out_valid && out_ready.
- Pointers: read and write pointers are clog2(DEPTH) bits and wrap modulo DEPTH. level increments on write-only, decrements on pop-only, and holds on simultaneous write+pop.
- s_count / l_count increment by 1 on each accepted write of that path and wrap at 2^CW.
- Storage contents are not reset. Only pointers, level, rr and the counters are reset.

## Timing
- Reset (rst_n low, asynchronous): level=0, out_valid=0, s_ready=1 and l_ready=1 subject to the arbitration rule on current inputs, rr=0, s_count=0, l_count=0, pointers=0. out_sum and out_path are don't-care while out_valid=0.
- Reset asserted mid-operation discards all buffered entries immediately. The first accepted write after release appears at the first read-pointer slot.
- Latency: a result accepted at edge N drives out_valid=1 with that result after edge N, i.e. one cycle minimum.
- Throughput: one result per cycle in and out in steady state.
- Ordering: output order equals accept order across both paths.
- Full (level=DEPTH): both readies are 0. After a pop at edge N, readies rise after edge N.
- Empty: out_ready is ignored, and level does not underflow.

## Test plan
- Reset: hold rst_n=0 with random inputs → level=0, out_valid=0, s_count=l_count=0. With s_valid=l_valid=1: s_ready=1, l_ready=0.
- Single small: s_sum=4'hF, s_cout=1, s_valid for one cycle, out_ready=1 → next cycle out_valid=1, out_sum=9'h01F, out_path=0; s_count=1; then out_valid=0.
- Single large: l_sum=8'hA5, l_cout=1 → out_sum=9'h1A5, out_path=1, l_count=1.
- Contention: both valid for 4 cycles with constant data (small 4'h3/0, large 8'h80/0), out_ready=1 → outputs alternate 003/0, 080/1, 003/0, 080/1. After small is accepted and both then request, large is granted.
- Full and stall: DEPTH=4, out_ready=0, s_valid held with sums 1..6 → entries 1..4 accepted, s_ready=0 at level=4. Raise out_ready with the same stimulus → outputs 1,2,3,… in order with no loss or duplication. During simultaneous write+pop, level stays constant.
- Mid-operation reset: at level=3, pulse rst_n low → level=0 and out_valid=0 at once. After release, push large 8'h01 → out_sum=9'h001 as the first output.

Source files
------------

// File: rtl/adder_result_merge.sv
// Merges small- and large-adder results into one in-order, path-tagged stream
// through a show-ahead FIFO with round-robin arbitration between the paths.
module adder_result_merge #(
    parameter int DEPTH = 4,
    parameter int CW    = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       s_valid,
    input  logic [3:0]                 s_sum,
    input  logic                       s_cout,
    output logic                       s_ready,
    input  logic                       l_valid,
    input  logic [7:0]                 l_sum,
    input  logic                       l_cout,
    output logic                       l_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [8:0]                 out_sum,
    output logic                       out_path,
    output logic [$clog2(DEPTH):0]     level,
    output logic [CW-1:0]              s_count,
    output logic [CW-1:0]              l_count
);
    localparam int AW = $clog2(DEPTH);

    logic [8:0]    mem_sum  [DEPTH];
    logic          mem_path [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          rr;
    logic          full, wr_s, wr_l, wr, pop;
    logic [8:0]    wr_sum;

    assign full      = (level == (AW+1)'(DEPTH));
    // rr=0 favours small, rr=1 favours large; only matters when both request
    assign s_ready   = !full && (!l_valid || !rr);
    assign l_ready   = !full && (!s_valid ||  rr);
    assign wr_s      = s_valid && s_ready;
    assign wr_l      = l_valid && l_ready;
    assign wr        = wr_s || wr_l;
    assign wr_sum    = wr_l ? {l_cout, l_sum} : {4'b0, s_cout, s_sum};
    assign out_valid = (level != '0);
    assign pop       = out_valid && out_ready;
    assign out_sum   = mem_sum[rd_ptr];
    assign out_path  = mem_path[rd_ptr];

    // Storage carries no reset; validity is tracked by level alone
    always_ff @(posedge clk) begin
        if (wr) begin
            mem_sum[wr_ptr]  <= wr_sum;
            mem_path[wr_ptr] <= wr_l;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            rr      <= 1'b0;
            s_count <= '0;
            l_count <= '0;
        end else begin
            if (wr)  wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (wr && !pop)      level <= level + (AW+1)'(1);
            else if (!wr && pop) level <= level - (AW+1)'(1);
            if (wr_s) begin
                rr      <= 1'b1;
                s_count <= s_count + CW'(1);
            end else if (wr_l) begin
                rr      <= 1'b0;
                l_count <= l_count + CW'(1);
            end
        end
    end
endmodule
